// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, VRAM geometry and the DAC expansion helper.
// No logic of its own; imported by the timing generator and the VRAM reader.
package vga_pkg;

    localparam int PIX_DIV = 4;
    localparam int SCALE   = 5;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int VRAM_COLS = 128;
    localparam int VRAM_ROWS = 96;
    localparam int ADDR_W    = 14;
    localparam int COL_W     = 7;
    localparam int ROW_W     = 7;
    localparam int DAC_W     = 4;

    localparam int CNT_W = 10;
    localparam int SC_W  = 3;
    localparam int DIV_W = 2;

    // One VRAM bit drives the whole DAC word, forced dark outside the visible area.
    function automatic logic [DAC_W-1:0] dac_expand(input logic bit_in, input logic vis);
        return (bit_in && vis) ? {DAC_W{1'b1}} : {DAC_W{1'b0}};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider plus horizontal/vertical counters; counters step once per tick.
// Sync and visible terms are combinational from the current counter values.
module vga_timing
    import vga_pkg::*;
#(
    parameter int PIX_DIV_P = PIX_DIV,
    parameter int H_VIS_P   = H_VIS,
    parameter int H_FP_P    = H_FP,
    parameter int H_SYNC_P  = H_SYNC,
    parameter int H_BP_P    = H_BP,
    parameter int V_VIS_P   = V_VIS,
    parameter int V_FP_P    = V_FP,
    parameter int V_SYNC_P  = V_SYNC,
    parameter int V_BP_P    = V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic [DIV_W-1:0] div,
    output logic             tick,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             line_end,
    output logic             v_last,
    output logic             visible,
    output logic             hsync_raw,
    output logic             vsync_raw
);

    localparam int H_TOT = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int V_TOT = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV_P - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS_P);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS_P);
    localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_VIS_P + H_FP_P);
    localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_VIS_P + H_FP_P + H_SYNC_P - 1);
    localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_VIS_P + V_FP_P);
    localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_VIS_P + V_FP_P + V_SYNC_P - 1);

    assign tick      = (div == DIV_LAST);
    assign line_end  = (h == H_LAST);
    assign v_last    = (v == V_LAST);
    assign visible   = (h < H_VIS_C) && (v < V_VIS_C);
    assign hsync_raw = !((h >= HS_LO) && (h <= HS_HI));
    assign vsync_raw = !((v >= VS_LO) && (v <= VS_HI));

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (line_end) begin
                    h <= '0;
                    v <= v_last ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_vram_reader.sv
// VRAM scan-out: scaled row/col address at tick edge, BRAM read next clk, DAC/sync registered 2 clk after tick.
// Free-running raster; no backpressure, outputs hold for PIX_DIV clocks per pixel.
module vga_vram_reader
    import vga_pkg::*;
#(
    parameter int PIX_DIV_P = PIX_DIV,
    parameter int SCALE_P   = SCALE,
    parameter int H_VIS_P   = H_VIS,
    parameter int H_FP_P    = H_FP,
    parameter int H_SYNC_P  = H_SYNC,
    parameter int H_BP_P    = H_BP,
    parameter int V_VIS_P   = V_VIS,
    parameter int V_FP_P    = V_FP,
    parameter int V_SYNC_P  = V_SYNC,
    parameter int V_BP_P    = V_BP
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    input  logic              red,
    input  logic              green,
    input  logic              blue,
    output logic [DAC_W-1:0]  vga_red,
    output logic [DAC_W-1:0]  vga_green,
    output logic [DAC_W-1:0]  vga_blue,
    output logic              hsync,
    output logic              vsync
);

    localparam logic [SC_W-1:0]  SC_LAST    = SC_W'(SCALE_P - 1);
    localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VIS_P);
    localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VIS_P);
    localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VIS_P - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VIS_P - 1);
    // Outputs load on the edge leaving div==1: the BRAM sampled the address one clock earlier.
    localparam logic [DIV_W-1:0] OUT_DIV    = DIV_W'(1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             line_end;
    logic             v_last;
    logic             visible;
    logic             hsync_raw;
    logic             vsync_raw;

    vga_timing #(
        .PIX_DIV_P (PIX_DIV_P),
        .H_VIS_P   (H_VIS_P),
        .H_FP_P    (H_FP_P),
        .H_SYNC_P  (H_SYNC_P),
        .H_BP_P    (H_BP_P),
        .V_VIS_P   (V_VIS_P),
        .V_FP_P    (V_FP_P),
        .V_SYNC_P  (V_SYNC_P),
        .V_BP_P    (V_BP_P)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .div       (div),
        .tick      (tick),
        .h         (h),
        .v         (v),
        .line_end  (line_end),
        .v_last    (v_last),
        .visible   (visible),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    logic [SC_W-1:0]  sx, sx_nxt;
    logic [SC_W-1:0]  sy, sy_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;

    // Next-state values describe the pixel h/v move to on this tick, so address tracks the new position.
    always_comb begin
        sx_nxt  = sx;
        sy_nxt  = sy;
        col_nxt = col;
        row_nxt = row;
        if (line_end) begin
            sx_nxt  = '0;
            col_nxt = '0;
            if (v_last || (v == V_VIS_LAST)) begin
                sy_nxt  = '0;
                row_nxt = '0;
            end else if (v < V_VIS_C) begin
                if (sy == SC_LAST) begin
                    sy_nxt  = '0;
                    row_nxt = row + 1'b1;
                end else begin
                    sy_nxt = sy + 1'b1;
                end
            end
        end else if (h < H_VIS_C) begin
            if (sx == SC_LAST) begin
                sx_nxt  = '0;
                col_nxt = (h == H_VIS_LAST) ? '0 : col + 1'b1;
            end else begin
                sx_nxt = sx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sx      <= '0;
            sy      <= '0;
            col     <= '0;
            row     <= '0;
            address <= '0;
        end else if (tick) begin
            sx      <= sx_nxt;
            sy      <= sy_nxt;
            col     <= col_nxt;
            row     <= row_nxt;
            address <= {row_nxt, col_nxt};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else if (div == OUT_DIV) begin
            vga_red   <= dac_expand(red, visible);
            vga_green <= dac_expand(green, visible);
            vga_blue  <= dac_expand(blue, visible);
            hsync     <= hsync_raw;
            vsync     <= vsync_raw;
        end
    end

endmodule

// File: tb/tb_vga_vram_reader.sv
// Bench for vga_vram_reader: full-size raster plus a shrunken raster sharing clock and reset.
module tb_vga_vram_reader;

    logic clk;
    logic reset;

    logic [13:0] address0, address1;
    logic        red0, green0, blue0, red1, green1, blue1;
    logic [3:0]  vr0, vg0, vb0, vr1, vg1, vb1;
    logic        hs0, vs0, hs1, vs1;

    bit [2:0] img0 [0:16383];
    bit [2:0] img1 [0:16383];

    longint n;
    int     vectors;
    int     miscompares;

    localparam logic [27:0] RST_VEC = {14'd0, 12'd0, 2'b11};

    vga_vram_reader u_big (
        .clk       (clk),
        .reset     (reset),
        .address   (address0),
        .red       (red0),
        .green     (green0),
        .blue      (blue0),
        .vga_red   (vr0),
        .vga_green (vg0),
        .vga_blue  (vb0),
        .hsync     (hs0),
        .vsync     (vs0)
    );

    vga_vram_reader #(
        .SCALE_P  (2),
        .H_VIS_P  (40),
        .H_FP_P   (4),
        .H_SYNC_P (8),
        .H_BP_P   (4),
        .V_VIS_P  (24),
        .V_FP_P   (2),
        .V_SYNC_P (2),
        .V_BP_P   (2)
    ) u_small (
        .clk       (clk),
        .reset     (reset),
        .address   (address1),
        .red       (red1),
        .green     (green1),
        .blue      (blue1),
        .vga_red   (vr1),
        .vga_green (vg1),
        .vga_blue  (vb1),
        .hsync     (hs1),
        .vsync     (vs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        {red0, green0, blue0} <= img0[address0];
        {red1, green1, blue1} <= img1[address1];
    end

    always @(posedge clk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    wire [27:0] obs0 = {address0, vr0, vg0, vb0, hs0, vs0};
    wire [27:0] obs1 = {address1, vr1, vg1, vb1, hs1, vs1};

    // Expected {address, r, g, b, hsync, vsync} after n non-reset edges, from raster arithmetic.
    function automatic logic [27:0] model(input int inst, input longint nn);
        int sc, hv, ht, hsa, hsb, vv, vt, vsa, vsb;
        int h, v, ah, av;
        longint t, p, m;
        logic [13:0] a, pa;
        logic [2:0]  px;
        logic [3:0]  r, g, b;
        logic        hs, vs;
        if (inst == 0) begin
            sc = 5; hv = 640; ht = 800; hsa = 656; hsb = 751; vv = 480; vt = 525; vsa = 490; vsb = 491;
        end else begin
            sc = 2; hv = 40;  ht = 56;  hsa = 44;  hsb = 51;  vv = 24;  vt = 30;  vsa = 26;  vsb = 27;
        end
        t  = nn / 4;
        p  = t % (ht * vt);
        ah = int'(p % ht);
        av = int'(p / ht);
        a  = 14'((av < vv ? av / sc : 0) * 128 + (ah < hv ? ah / sc : 0));
        r = 4'h0; g = 4'h0; b = 4'h0; hs = 1'b1; vs = 1'b1;
        if (nn >= 2) begin
            m = nn - ((nn - 2) % 4);
            t = m / 4;
            p = t % (ht * vt);
            h = int'(p % ht);
            v = int'(p / ht);
            if (h < hv && v < vv) begin
                pa = 14'((v / sc) * 128 + (h / sc));
                px = (inst == 0) ? img0[pa] : img1[pa];
                r = {4{px[2]}};
                g = {4{px[1]}};
                b = {4{px[0]}};
            end
            hs = !(h >= hsa && h <= hsb);
            vs = !(v >= vsa && v <= vsb);
        end
        return {a, r, g, b, hs, vs};
    endfunction

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 16384; a++) begin
            img0[a] = 3'($urandom);
            img1[a] = 3'($urandom);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        fill_random();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (obs0 !== RST_VEC) begin
                miscompares++;
                $display("FAIL reset_big cycle %0d: got %h expected %h", i, obs0, RST_VEC);
            end
            vectors++;
            if (obs1 !== RST_VEC) begin
                miscompares++;
                $display("FAIL reset_small cycle %0d: got %h expected %h", i, obs1, RST_VEC);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_line_timing();
        logic [27:0] e0, e1;
        logic p_hs0, p_vs1;
        int   fall_h, per_h, wid_h, fall_v, wid_v;
        fall_h = -1; per_h = -1; wid_h = -1; fall_v = -1; wid_v = -1;
        p_hs0 = 1'b1; p_vs1 = 1'b1;
        for (int i = 0; i < 9800; i++) begin
            @(negedge clk);
            e0 = model(0, n);
            e1 = model(1, n);
            vectors++;
            if (obs0 !== e0) begin
                miscompares++;
                $display("FAIL timing_big n=%0d: got %h expected %h", n, obs0, e0);
            end
            vectors++;
            if (obs1 !== e1) begin
                miscompares++;
                $display("FAIL timing_small n=%0d: got %h expected %h", n, obs1, e1);
            end
            if (p_hs0 && !hs0) begin
                if (fall_h >= 0) per_h = i - fall_h;
                fall_h = i;
            end
            if (!p_hs0 && hs0 && fall_h >= 0) wid_h = i - fall_h;
            if (p_vs1 && !vs1) fall_v = i;
            if (!p_vs1 && vs1 && fall_v >= 0) wid_v = i - fall_v;
            p_hs0 = hs0;
            p_vs1 = vs1;
        end
        vectors++;
        if (per_h !== 3200) begin
            miscompares++;
            $display("FAIL hsync_period: got %0d expected 3200", per_h);
        end
        vectors++;
        if (wid_h !== 384) begin
            miscompares++;
            $display("FAIL hsync_width: got %0d expected 384", wid_h);
        end
        vectors++;
        if (wid_v !== 448) begin
            miscompares++;
            $display("FAIL vsync_width_small: got %0d expected 448", wid_v);
        end
    endtask

    task automatic test_green_only();
        logic [27:0] e0, e1;
        for (int a = 0; a < 16384; a++) begin
            img0[a] = 3'b010;
            img1[a] = 3'b010;
        end
        apply_reset(10);
        for (int i = 0; i < 6500; i++) begin
            @(negedge clk);
            e0 = model(0, n);
            e1 = model(1, n);
            vectors++;
            if (obs0 !== e0) begin
                miscompares++;
                $display("FAIL green_big n=%0d: got %h expected %h", n, obs0, e0);
            end
            vectors++;
            if (obs1 !== e1) begin
                miscompares++;
                $display("FAIL green_small n=%0d: got %h expected %h", n, obs1, e1);
            end
        end
    endtask

    task automatic test_row_stripes();
        logic [27:0] e0, e1;
        logic [13:0] ai;
        for (int a = 0; a < 16384; a++) begin
            ai = 14'(a);
            img0[a] = {3{ai[7]}};
            img1[a] = {3{ai[7]}};
        end
        apply_reset(10);
        for (int i = 0; i < 35200; i++) begin
            @(negedge clk);
            e0 = model(0, n);
            e1 = model(1, n);
            vectors++;
            if (obs0 !== e0) begin
                miscompares++;
                $display("FAIL stripes_big n=%0d: got %h expected %h", n, obs0, e0);
            end
            vectors++;
            if (obs1 !== e1) begin
                miscompares++;
                $display("FAIL stripes_small n=%0d: got %h expected %h", n, obs1, e1);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [27:0] e0, e1;
        apply_reset(10);
        fill_random();
        for (int i = 0; i < 8000 && n < 7601; i++) begin
            @(negedge clk);
            e0 = model(0, n);
            vectors++;
            if (obs0 !== e0) begin
                miscompares++;
                $display("FAIL prereset_big n=%0d: got %h expected %h", n, obs0, e0);
            end
        end
        vectors++;
        if (n != 7601) begin
            miscompares++;
            $display("FAIL midreset_reach: got n=%0d expected 7601", n);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (obs0 !== RST_VEC) begin
            miscompares++;
            $display("FAIL midreset_big: got %h expected %h", obs0, RST_VEC);
        end
        vectors++;
        if (obs1 !== RST_VEC) begin
            miscompares++;
            $display("FAIL midreset_small: got %h expected %h", obs1, RST_VEC);
        end
        for (int i = 0; i < 3400; i++) begin
            @(negedge clk);
            e0 = model(0, n);
            e1 = model(1, n);
            vectors++;
            if (obs0 !== e0) begin
                miscompares++;
                $display("FAIL restart_big n=%0d: got %h expected %h", n, obs0, e0);
            end
            vectors++;
            if (obs1 !== e1) begin
                miscompares++;
                $display("FAIL restart_small n=%0d: got %h expected %h", n, obs1, e1);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        test_reset();
        test_line_timing();
        test_green_only();
        test_row_stripes();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
